// File: rtl/pulse_burst_generator_if.sv
// Control-side bundle of the pulse burst generator:
// start/abort requests, burst configuration and status.
interface pulse_burst_generator_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   delay_cfg;
    logic [CNT_W-1:0]   width_cfg;
    logic [CNT_W-1:0]   gap_cfg;
    logic [BURST_W-1:0] count_cfg;
    logic               pulse_out;
    logic               busy;
    logic               done;
    logic               ready;

    modport master (
        output start, abort,
        output delay_cfg, width_cfg,
        output gap_cfg, count_cfg,
        input  pulse_out, busy,
        input  done, ready
    );

    modport slave (
        input  start, abort,
        input  delay_cfg, width_cfg,
        input  gap_cfg, count_cfg,
        output pulse_out, busy,
        output done, ready
    );
endinterface

// File: rtl/pulse_burst_generator.sv
// Programmable pulse burst generator: delay, then N pulses
// of programmable width and gap; N=0 runs until abort.
module pulse_burst_generator #(
    parameter int CNT_W       = 16,
    parameter int BURST_W     = 8,
    parameter int RESET_DELAY = 3
) (
    input  logic clk,
    input  logic reset,
    pulse_burst_generator_if.slave bus
);
    localparam int RD_W    = $clog2(RESET_DELAY + 2);
    localparam int RD_EDGE = (RESET_DELAY == 0) ? 1 : RESET_DELAY;
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(RD_EDGE - 1);

    typedef enum logic [2:0] {
        WAIT_READY,
        IDLE,
        DELAY,
        HIGH,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   wm1_q, wm1_d;
    logic [CNT_W-1:0]   gm1_q, gm1_d;
    logic [BURST_W-1:0] num_q, num_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    // Phase length minus one; a zero length behaves as one cycle.
    function automatic logic [CNT_W-1:0] len_m1(
        input logic [CNT_W-1:0] v
    );
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wm1_d   = wm1_q;
        gm1_d   = gm1_q;
        num_d   = num_q;
        pcnt_d  = pcnt_q;
        rd_d    = rd_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        unique case (state_q)
            WAIT_READY: begin
                if (rd_q == RD_LAST) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_d = rd_q + RD_W'(1);
                end
            end
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cnt_d   = bus.delay_cfg;
                    wm1_d   = len_m1(bus.width_cfg);
                    gm1_d   = len_m1(bus.gap_cfg);
                    num_d   = bus.count_cfg;
                    pcnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY, GAP: begin
                if (cnt_q == '0) begin
                    pulse_d = 1'b1;
                    cnt_d   = wm1_q;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    pulse_d = 1'b0;
                    pcnt_d  = pcnt_q + BURST_W'(1);
                    // Continuous mode (num_q=0) never terminates here.
                    if (num_q != '0 &&
                        (pcnt_q + BURST_W'(1)) == num_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = gm1_q;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && busy_q) begin
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_READY;
            cnt_q   <= '0;
            wm1_q   <= '0;
            gm1_q   <= '0;
            num_q   <= '0;
            pcnt_q  <= '0;
            rd_q    <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wm1_q   <= wm1_d;
            gm1_q   <= gm1_d;
            num_q   <= num_d;
            pcnt_q  <= pcnt_d;
            rd_q    <= rd_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ready     = ready_q;
endmodule
